// File: rtl/i2c_scl_phase_gen_if.sv
//------------------------------------------------------------------------------
// Module  : i2c_scl_phase_gen_if
// Brief   : Control and phase-decode bundle between the I2C bit sequencer and
//           the SCL quarter-phase generator.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface i2c_scl_phase_gen_if;
   logic       ena;
   logic       scl_in;
   logic       tmo_clr;
   logic       scl_clk;
   logic       data_clk;
   logic       switch_range;
   logic [1:0] phase;
   logic       data_rise;
   logic       data_fall;
   logic       stretching;
   logic       timeout;

   // Sequencer side: issues enable/clear and forwards the bus SCL level
   modport master (
      output ena, scl_in, tmo_clr,
      input  scl_clk, data_clk, switch_range, phase,
             data_rise, data_fall, stretching, timeout
   );

   // Generator side
   modport slave (
      input  ena, scl_in, tmo_clr,
      output scl_clk, data_clk, switch_range, phase,
             data_rise, data_fall, stretching, timeout
   );
endinterface

`default_nettype wire

// File: rtl/i2c_scl_phase_gen.sv
//------------------------------------------------------------------------------
// Module  : i2c_scl_phase_gen
// Brief   : I2C master bit-clock generator: 4-quarter SCL period, quarter-phase
//           decode, data-edge strobes and slave clock stretching with timeout.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module i2c_scl_phase_gen #(
   parameter int DIVIDER    = 5000,
   parameter int CBITS      = 15,
   parameter int SAMPLE_OFS = 2,
   parameter int TIMEOUT    = 65535,
   parameter int TBITS      = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   i2c_scl_phase_gen_if.slave   bus
);

   if ((DIVIDER < 2) || (CBITS < 1) || (CBITS > 30) ||
       ((4 * DIVIDER - 1) >= (1 << CBITS))) begin : g_bad_divider
      $error("i2c_scl_phase_gen: DIVIDER/CBITS out of range");
   end
   if ((SAMPLE_OFS < 0) || (SAMPLE_OFS >= DIVIDER)) begin : g_bad_sample_ofs
      $error("i2c_scl_phase_gen: SAMPLE_OFS out of range");
   end
   if ((TIMEOUT < 1) || (TBITS < 1) || (TBITS > 30) ||
       (TIMEOUT >= (1 << TBITS))) begin : g_bad_timeout
      $error("i2c_scl_phase_gen: TIMEOUT/TBITS out of range");
   end

   localparam logic [CBITS-1:0] C_Q1     = CBITS'(DIVIDER);
   localparam logic [CBITS-1:0] C_Q2     = CBITS'(2 * DIVIDER);
   localparam logic [CBITS-1:0] C_Q3     = CBITS'(3 * DIVIDER);
   localparam logic [CBITS-1:0] C_LAST   = CBITS'(4 * DIVIDER - 1);
   localparam logic [CBITS-1:0] C_SAMPLE = CBITS'(2 * DIVIDER + SAMPLE_OFS);
   localparam logic [TBITS-1:0] C_TMO    = TBITS'(TIMEOUT);

   logic [CBITS-1:0] cnt_q, cnt_d;
   logic [TBITS-1:0] str_cnt_q, str_cnt_d;
   logic             run_q, run_d;
   logic             scl_clk_q, scl_clk_d;
   logic             data_clk_q, data_clk_d;
   logic             switch_range_q, switch_range_d;
   logic [1:0]       phase_q, phase_d;
   logic             data_rise_q, data_rise_d;
   logic             data_fall_q, data_fall_d;
   logic             stretching_q, stretching_d;
   logic             timeout_q, timeout_d;
   logic             tmo_set;

   always_comb begin
      cnt_d          = '0;
      str_cnt_d      = '0;
      run_d          = 1'b0;
      stretching_d   = 1'b0;
      tmo_set        = 1'b0;
      scl_clk_d      = 1'b1;
      data_clk_d     = 1'b0;
      switch_range_d = 1'b0;
      phase_d        = 2'd0;
      data_rise_d    = 1'b0;
      data_fall_d    = 1'b0;

      if (bus.ena) begin
         run_d = 1'b1;
         // First enabled edge after idle/reset starts a fresh period at 0
         if (!run_q) begin
            cnt_d = '0;
         end else if ((cnt_q == C_SAMPLE) && !bus.scl_in) begin
            if (str_cnt_q == C_TMO) begin
               tmo_set = 1'b1;
               cnt_d   = cnt_q + CBITS'(1);
            end else begin
               cnt_d        = cnt_q;
               str_cnt_d    = str_cnt_q + TBITS'(1);
               stretching_d = 1'b1;
            end
         end else if (cnt_q == C_LAST) begin
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + CBITS'(1);
         end

         // Outputs decode the new count so they line up with it
         if (cnt_d < C_Q1) begin
            phase_d = 2'd0;
         end else if (cnt_d < C_Q2) begin
            phase_d = 2'd1;
         end else if (cnt_d < C_Q3) begin
            phase_d = 2'd2;
         end else begin
            phase_d = 2'd3;
         end
         scl_clk_d      = phase_d[1];
         data_clk_d     = phase_d[1] ^ phase_d[0];
         switch_range_d = (phase_d == 2'd2);
         data_rise_d    = (cnt_d == C_Q1);
         data_fall_d    = (cnt_d == C_Q3);
      end

      timeout_d = tmo_set | (timeout_q & ~bus.tmo_clr);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q          <= '0;
         str_cnt_q      <= '0;
         run_q          <= 1'b0;
         scl_clk_q      <= 1'b1;
         data_clk_q     <= 1'b0;
         switch_range_q <= 1'b0;
         phase_q        <= 2'd0;
         data_rise_q    <= 1'b0;
         data_fall_q    <= 1'b0;
         stretching_q   <= 1'b0;
         timeout_q      <= 1'b0;
      end else begin
         cnt_q          <= cnt_d;
         str_cnt_q      <= str_cnt_d;
         run_q          <= run_d;
         scl_clk_q      <= scl_clk_d;
         data_clk_q     <= data_clk_d;
         switch_range_q <= switch_range_d;
         phase_q        <= phase_d;
         data_rise_q    <= data_rise_d;
         data_fall_q    <= data_fall_d;
         stretching_q   <= stretching_d;
         timeout_q      <= timeout_d;
      end
   end

   assign bus.scl_clk      = scl_clk_q;
   assign bus.data_clk     = data_clk_q;
   assign bus.switch_range = switch_range_q;
   assign bus.phase        = phase_q;
   assign bus.data_rise    = data_rise_q;
   assign bus.data_fall    = data_fall_q;
   assign bus.stretching   = stretching_q;
   assign bus.timeout      = timeout_q;

endmodule

`default_nettype wire
